// File: rtl/lane_packer.sv
// Stream-to-vector packer: serial words fill lanes 0..NUM_INPUT-1, closed on full or s_last.
// Define LANE_PACKER_DBUF_EN for a shadow fill bank that keeps accepting while the output is held.
module lane_packer #(
  parameter int NUM_INPUT = 8,
  parameter int WIDTH_IN  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [WIDTH_IN-1:0]  s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [WIDTH_IN-1:0]  m_data [NUM_INPUT],
  output logic [NUM_INPUT-1:0] m_ctr,
  output logic                 m_last,
  output logic                 m_valid,
  input  logic                 m_ready
);
  localparam int IDXW = $clog2(NUM_INPUT);
`ifdef LANE_PACKER_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  typedef enum logic {S_FILL, S_HOLD} state_e;
  typedef logic [WIDTH_IN-1:0] lane_t;

  state_e               state_q, state_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  lane_t                fdata_q [NUM_INPUT];
  lane_t                fdata_d [NUM_INPUT];
  logic [NUM_INPUT-1:0] fctr_q, fctr_d;
  logic                 flast_q, flast_d;
  lane_t                odata_q [NUM_INPUT];
  lane_t                odata_d [NUM_INPUT];
  logic [NUM_INPUT-1:0] octr_q, octr_d;
  logic                 olast_q, olast_d;
  logic                 ovld_q, ovld_d;

  lane_t                nb_data [NUM_INPUT];
  logic [NUM_INPUT-1:0] nb_ctr;
  logic                 nb_last;
  logic                 in_xfer, out_xfer, close, load_out;

  assign s_ready  = ena & (state_q == S_FILL);
  assign in_xfer  = s_valid & s_ready;
  assign out_xfer = ovld_q & m_ready & ena;
  assign close    = in_xfer & ((idx_q == IDXW'(NUM_INPUT - 1)) | s_last);

  // The fill bank moves to the output on close if the output slot is free or
  // being drained this edge; a bank closed earlier moves on the drain itself.
  assign load_out = DBUF ? ((close & (~ovld_q | out_xfer)) | ((state_q == S_HOLD) & out_xfer))
                         : close;

  // Fill bank as it looks with this cycle's word written in.
  always_comb begin
    nb_data = fdata_q;
    nb_ctr  = fctr_q;
    nb_last = flast_q;
    if (in_xfer) begin
      nb_data[idx_q] = s_data;
      nb_ctr[idx_q]  = 1'b1;
      nb_last        = s_last;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fdata_d = fdata_q;
    fctr_d  = fctr_q;
    flast_d = flast_q;
    odata_d = odata_q;
    octr_d  = octr_q;
    olast_d = olast_q;
    ovld_d  = ovld_q;
    if (in_xfer) begin
      fdata_d = nb_data;
      fctr_d  = nb_ctr;
      flast_d = nb_last;
      idx_d   = close ? '0 : idx_q + IDXW'(1);
    end
    if (out_xfer) begin
      odata_d = '{default: '0};
      octr_d  = '0;
      olast_d = 1'b0;
      ovld_d  = 1'b0;
      state_d = S_FILL;
    end
    if (load_out) begin
      odata_d = nb_data;
      octr_d  = nb_ctr;
      olast_d = nb_last;
      ovld_d  = 1'b1;
      fdata_d = '{default: '0};
      fctr_d  = '0;
      flast_d = 1'b0;
    end
    // Single bank: every close blocks input. Shadow bank: only a close that cannot move out.
    if (close && (!DBUF || !load_out)) state_d = S_HOLD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FILL;
      idx_q   <= '0;
      fdata_q <= '{default: '0};
      fctr_q  <= '0;
      flast_q <= 1'b0;
      odata_q <= '{default: '0};
      octr_q  <= '0;
      olast_q <= 1'b0;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fdata_q <= fdata_d;
      fctr_q  <= fctr_d;
      flast_q <= flast_d;
      odata_q <= odata_d;
      octr_q  <= octr_d;
      olast_q <= olast_d;
      ovld_q  <= ovld_d;
    end
  end

  assign m_data  = odata_q;
  assign m_ctr   = octr_q;
  assign m_last  = olast_q;
  assign m_valid = ovld_q;

endmodule

// File: tb/tb_lane_packer.sv
// Bench for lane_packer (NUM_INPUT=4, WIDTH_IN=8): frame table plus backpressure, enable,
// reset and streaming sequences; expected vectors are queued when driven, checked on transfer.
module tb_lane_packer;
  localparam int N = 4;
  localparam int W = 8;
`ifdef LANE_PACKER_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, ena, s_valid, s_last, s_ready, m_last, m_valid, m_ready;
  logic [W-1:0] s_data;
  logic [W-1:0] m_data [N];
  logic [N-1:0] m_ctr;

  int checks = 0, errors = 0, nvec = 0, mv_cycles = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  c;
    logic        l;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int             n;
    logic [3:0][7:0] w;
    logic           last;
    logic [31:0]    exp_d;
    logic [3:0]     exp_c;
    logic           exp_l;
  } vec_t;
  vec_t tbl [6];

  lane_packer #(.NUM_INPUT(N), .WIDTH_IN(W)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_ctr(m_ctr), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  function automatic logic [31:0] pk();
    return {m_data[3], m_data[2], m_data[1], m_data[0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] c, input logic l);
    exp_t e;
    e.d = d; e.c = c; e.l = l;
    sb.push_back(e);
  endtask

  // Scoreboard: every output transfer must match the oldest queued vector.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ena && m_valid) mv_cycles++;
    if (!rst && ena && m_valid && m_ready) begin
      nvec++;
      chk("sb_has_entry", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("vec_data", pk(), e.d);
        chk("vec_ctr", 32'(m_ctr), 32'(e.c));
        chk("vec_last", 32'(m_last), 32'(e.l));
      end
    end
  end

  task automatic send_word(input logic [7:0] d, input logic l);
    int t = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    @(negedge clk);
    while (!s_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    chk("s_ready_wait", 32'(t < 50), 1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk); #1;
    chk("drain", 32'(sb.size()), 0);
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  initial begin
    logic [31:0] hold;
    logic [7:0]  wd;
    int          acc, cyc, n0;
    logic        got;

    tbl[0] = '{4, 32'h04030201, 1'b0, 32'h04030201, 4'b1111, 1'b0};
    tbl[1] = '{2, 32'h00000605, 1'b1, 32'h00000605, 4'b0011, 1'b1};
    tbl[2] = '{1, 32'h00000007, 1'b1, 32'h00000007, 4'b0001, 1'b1};
    tbl[3] = '{4, 32'h0c0b0a09, 1'b1, 32'h0c0b0a09, 4'b1111, 1'b1};
    tbl[4] = '{3, 32'h00ffee80, 1'b1, 32'h00ffee80, 4'b0111, 1'b1};
    tbl[5] = '{4, 32'hdeadbeef, 1'b0, 32'hdeadbeef, 4'b1111, 1'b0};

    rst = 1'b1; ena = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_ctr", 32'(m_ctr), 0);
    chk("rst_m_data", pk(), 0);
    chk("rst_m_last", 32'(m_last), 0);
    chk("rst_s_ready", 32'(s_ready), 1);
    @(posedge clk); #1;

    // Frame table, consumer always ready
    for (int i = 0; i < 6; i++) begin
      push(tbl[i].exp_d, tbl[i].exp_c, tbl[i].exp_l);
      for (int k = 0; k < tbl[i].n; k++)
        send_word(tbl[i].w[k], tbl[i].last && (k == tbl[i].n - 1));
    end
    drain();
    chk("table_nvec", nvec, 6);
    chk("table_valid_cycles", mv_cycles, 6);

    // Backpressure: 5 held cycles with input offered throughout
    m_ready = 1'b0;
    push(32'h24232221, 4'b1111, 1'b0);
    for (int k = 0; k < 4; k++) send_word(8'(8'h21 + k), 1'b0);
    hold = pk();
    if (DBUF) push(32'h34333231, 4'b1111, 1'b0);
    acc = 0; wd = 8'h31;
    s_valid = 1'b1; s_data = wd; s_last = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", 32'(m_valid), 1);
      chk("bp_data", pk(), hold);
      chk("bp_ctr", 32'(m_ctr), 32'hf);
      got = s_ready;
      if (got) acc++;
      @(posedge clk); #1;
      if (got) begin wd = wd + 8'd1; s_data = wd; end
    end
    s_valid = 1'b0;
    chk("bp_accepted", acc, DBUF ? 4 : 0);
    @(negedge clk);
    chk("bp_ready_after", 32'(s_ready), 0);
    @(posedge clk); #1; m_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_next_valid", 32'(m_valid), DBUF ? 1 : 0);
    chk("bp_ready_resume", 32'(s_ready), 1);
    drain();

    // Enable stall mid-fill, then while the vector is held
    push(32'hd4c3b2a1, 4'b1111, 1'b0);
    send_word(8'ha1, 1'b0);
    send_word(8'hb2, 1'b0);
    ena = 1'b0; s_valid = 1'b1; s_data = 8'hc3;
    repeat (3) begin
      @(negedge clk);
      chk("stall_s_ready", 32'(s_ready), 0);
      chk("stall_m_valid", 32'(m_valid), 0);
      @(posedge clk); #1;
    end
    ena = 1'b1;
    send_word(8'hc3, 1'b0);
    send_word(8'hd4, 1'b0);
    ena = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("stall_hold_valid", 32'(m_valid), 1);
      chk("stall_hold_ctr", 32'(m_ctr), 32'hf);
      @(posedge clk); #1;
    end
    ena = 1'b1;
    drain();

    // Reset while a vector is held
    m_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_word(8'(8'h41 + k), 1'b0);
    @(negedge clk);
    chk("rh_valid_before", 32'(m_valid), 1);
    pulse_rst();
    @(negedge clk);
    chk("rh_m_valid", 32'(m_valid), 0);
    chk("rh_m_ctr", 32'(m_ctr), 0);
    chk("rh_m_data", pk(), 0);
    chk("rh_m_last", 32'(m_last), 0);
    @(posedge clk); #1;
    m_ready = 1'b1;
    push(32'h00000055, 4'b0001, 1'b1);
    send_word(8'h55, 1'b1);
    drain();

    // Reset mid-fill discards the partial vector
    send_word(8'h61, 1'b0);
    send_word(8'h62, 1'b0);
    pulse_rst();
    push(32'h00000077, 4'b0001, 1'b1);
    send_word(8'h77, 1'b1);
    drain();

    // Streaming: 12 words offered continuously
    n0 = nvec;
    push(32'h84838281, 4'b1111, 1'b0);
    push(32'h88878685, 4'b1111, 1'b0);
    push(32'h8c8b8a89, 4'b1111, 1'b0);
    acc = 0; cyc = 0; wd = 8'h81;
    s_valid = 1'b1; s_data = wd; s_last = 1'b0;
    while (acc < 12 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      got = s_ready;
      if (got) acc++;
      @(posedge clk); #1;
      if (got) begin wd = wd + 8'd1; s_data = wd; end
    end
    s_valid = 1'b0;
    chk("b2b_words", acc, 12);
    chk("b2b_cycles", cyc, DBUF ? 12 : 14);
    drain();
    chk("b2b_vectors", nvec - n0, 3);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
